// File: rtl/riscv_pkg.sv
// Shared RV32 decode vocabulary: opcodes, funct7 values, format codes and the
// per-instruction field extraction used by the decode pipeline stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [2:0] {
    TIPO_I      = 3'b000,
    TIPO_U      = 3'b001,
    TIPO_S      = 3'b010,
    TIPO_R      = 3'b011,
    TIPO_ILEGAL = 3'b100,
    TIPO_SB     = 3'b110,
    TIPO_UJ     = 3'b111
  } tipo_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    tipo_t      tipo;
    logic       ilegal;
  } campos_t;

  function automatic tipo_t tipo_de_opcode(input logic [6:0] opc);
    tipo_t t;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = TIPO_I;
      OPC_STORE:                      t = TIPO_S;
      OPC_OP:                         t = TIPO_R;
      OPC_BRANCH:                     t = TIPO_SB;
      OPC_LUI, OPC_AUIPC:             t = TIPO_U;
      OPC_JAL:                        t = TIPO_UJ;
      default:                        t = TIPO_ILEGAL;
    endcase
    return t;
  endfunction

  function automatic logic funct7_legal(input logic [6:0] f7, input logic suporta_m);
    return (f7 == F7_BASE) || (f7 == F7_ALT) || (suporta_m && (f7 == F7_MULDIV));
  endfunction

  // Only the fields a format actually carries are passed through; everything
  // else is forced to zero so downstream never sees stale register indices.
  function automatic campos_t decodifica(input logic [31:0] inst, input logic suporta_m);
    campos_t c;
    c        = '0;
    c.opcode = inst[6:0];
    c.tipo   = tipo_de_opcode(inst[6:0]);
    c.ilegal = (c.tipo == TIPO_ILEGAL);
    case (c.tipo)
      TIPO_I: begin
        c.rd     = inst[11:7];
        c.rs1    = inst[19:15];
        c.funct3 = inst[14:12];
      end
      TIPO_S, TIPO_SB: begin
        c.rs1    = inst[19:15];
        c.rs2    = inst[24:20];
        c.funct3 = inst[14:12];
      end
      TIPO_R: begin
        c.rd     = inst[11:7];
        c.rs1    = inst[19:15];
        c.rs2    = inst[24:20];
        c.funct3 = inst[14:12];
        c.funct7 = inst[31:25];
        c.ilegal = !funct7_legal(inst[31:25], suporta_m);
      end
      TIPO_U, TIPO_UJ: begin
        c.rd     = inst[11:7];
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gerador_imediato.sv
// Combinational immediate builder: assembles the 32-bit immediate for the
// given format, then sign-extends from instruction bit 31 up to XLEN.
module gerador_imediato
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instrucao,
  input  tipo_t           tipo,
  output logic [XLEN-1:0] immediate
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instrucao[6:0];

  always_comb begin
    imm32 = '0;
    case (tipo)
      TIPO_I:  imm32 = {{20{instrucao[31]}}, instrucao[31:20]};
      TIPO_S:  imm32 = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
      TIPO_SB: imm32 = {{20{instrucao[31]}}, instrucao[7], instrucao[30:25],
                        instrucao[11:8], 1'b0};
      TIPO_U:  imm32 = {instrucao[31:12], 12'b0};
      TIPO_UJ: imm32 = {{12{instrucao[31]}}, instrucao[19:12], instrucao[20],
                        instrucao[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign immediate[31:0] = imm32;

  // R and illegal formats yield imm32 == 0, so extending bit 31 keeps them zero.
  genvar gi;
  generate
    for (gi = 32; gi < XLEN; gi++) begin : g_ext
      assign immediate[gi] = imm32[31];
    end
  endgenerate

endmodule

// File: rtl/decodificador_pipe.sv
// Single-register decode stage with valid/ready on both sides: decodes an
// RV32 word into fields/immediate and counts legal instructions consumed.
module decodificador_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CONT_W    = 16,
  parameter bit SUPORTA_M = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instrucao,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [XLEN-1:0]   immediate,
  output logic [2:0]        tipo,
  output logic              ilegal,
  output logic [CONT_W-1:0] contador
);

  campos_t           campos_next;
  campos_t           campos_reg;
  logic [XLEN-1:0]   imm_next;
  logic [XLEN-1:0]   imm_reg;
  logic              out_valid_reg;
  logic [CONT_W-1:0] contador_reg;
  logic              captura;
  logic              entrega;

  assign in_ready = !out_valid_reg || out_ready;
  assign captura  = in_valid && in_ready && !flush;
  assign entrega  = out_valid_reg && out_ready;

  always_comb begin
    campos_next = decodifica(instrucao, SUPORTA_M);
  end

  gerador_imediato #(
    .XLEN(XLEN)
  ) u_gerador_imediato (
    .instrucao (instrucao),
    .tipo      (campos_next.tipo),
    .immediate (imm_next)
  );

  // flush wins over capture; otherwise a consumed entry is replaced or emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      campos_reg    <= '0;
      imm_reg       <= '0;
    end else if (captura) begin
      out_valid_reg <= 1'b1;
      campos_reg    <= campos_next;
      imm_reg       <= imm_next;
    end else if (flush || out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // A transfer coinciding with flush is discarded and therefore not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_reg <= '0;
    end else if (entrega && !campos_reg.ilegal && !flush) begin
      contador_reg <= contador_reg + CONT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign opcode    = campos_reg.opcode;
  assign rd        = campos_reg.rd;
  assign rs1       = campos_reg.rs1;
  assign rs2       = campos_reg.rs2;
  assign funct3    = campos_reg.funct3;
  assign funct7    = campos_reg.funct7;
  assign tipo      = campos_reg.tipo;
  assign ilegal    = campos_reg.ilegal;
  assign immediate = imm_reg;
  assign contador  = contador_reg;

endmodule

// File: tb/tb_decodificador_pipe.sv
// Bench for decodificador_pipe: two instances (RV32 base, and XLEN=64 with M)
// share stimulus and are checked against a transaction-level reference model.
module tb_decodificador_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instrucao;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ilegal_a;
  logic [6:0]  opcode_a, funct7_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  funct3_a, tipo_a;
  logic [31:0] immediate_a;
  logic [15:0] contador_a;

  logic        in_ready_b, out_valid_b, ilegal_b;
  logic [6:0]  opcode_b, funct7_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [2:0]  funct3_b, tipo_b;
  logic [63:0] immediate_b;
  logic [15:0] contador_b;

  always #5 clk = ~clk;

  decodificador_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .instrucao(instrucao), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .opcode(opcode_a), .rd(rd_a), .rs1(rs1_a),
    .rs2(rs2_a), .funct3(funct3_a), .funct7(funct7_a),
    .immediate(immediate_a), .tipo(tipo_a), .ilegal(ilegal_a),
    .contador(contador_a)
  );

  decodificador_pipe #(.XLEN(64), .CONT_W(16), .SUPORTA_M(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .instrucao(instrucao), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .opcode(opcode_b), .rd(rd_b), .rs1(rs1_b),
    .rs2(rs2_b), .funct3(funct3_b), .funct7(funct7_b),
    .immediate(immediate_b), .tipo(tipo_b), .ilegal(ilegal_b),
    .contador(contador_b)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [2:0]  tipo;
    logic        ilegal;
  } exp_t;

  typedef struct {
    string       nome;
    logic [31:0] inst;
    logic [2:0]  tipo;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm32;
    logic        ilegal;
    logic [63:0] imm64;
    logic        ilegal_m;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   m_valid;
  exp_t m_a, m_b;
  logic [15:0] m_cnt_a, m_cnt_b;

  // Reference: immediates built from the arithmetic value of each format.
  function automatic exp_t ref_decode(input logic [31:0] i, input int xlen, input bit sup_m);
    exp_t   e;
    longint v;
    e = '{default: '0};
    v = 0;
    e.opcode = i[6:0];
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin
        e.tipo = 3'd0; e.rd = i[11:7]; e.rs1 = i[19:15]; e.funct3 = i[14:12];
        v = longint'($signed(i)) >>> 20;
      end
      7'h23: begin
        e.tipo = 3'd2; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.funct3 = i[14:12];
        v = (longint'($signed(i)) >>> 25) * 32 + longint'(i[11:7]);
      end
      7'h63: begin
        e.tipo = 3'd6; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.funct3 = i[14:12];
        v = (i[31] ? -64'sd4096 : 64'sd0) + longint'(i[7]) * 2048
            + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      7'h37, 7'h17: begin
        e.tipo = 3'd1; e.rd = i[11:7];
        v = longint'($signed(i & 32'hFFFFF000));
      end
      7'h6F: begin
        e.tipo = 3'd7; e.rd = i[11:7];
        v = (i[31] ? -64'sd1048576 : 64'sd0) + longint'(i[19:12]) * 4096
            + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      7'h33: begin
        e.tipo = 3'd3; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.funct3 = i[14:12]; e.funct7 = i[31:25];
        e.ilegal = !(i[31:25] == 7'h00 || i[31:25] == 7'h20 || (sup_m && i[31:25] == 7'h01));
      end
      default: begin
        e.tipo = 3'd4; e.ilegal = 1'b1;
      end
    endcase
    if (xlen == 32) v = v & 64'h00000000FFFFFFFF;
    e.imm = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input exp_t e);
    chk({tag, "_opcode_a"}, 64'(opcode_a), 64'(e.opcode));
    chk({tag, "_rd_a"},     64'(rd_a),     64'(e.rd));
    chk({tag, "_rs1_a"},    64'(rs1_a),    64'(e.rs1));
    chk({tag, "_rs2_a"},    64'(rs2_a),    64'(e.rs2));
    chk({tag, "_funct3_a"}, 64'(funct3_a), 64'(e.funct3));
    chk({tag, "_funct7_a"}, 64'(funct7_a), 64'(e.funct7));
    chk({tag, "_tipo_a"},   64'(tipo_a),   64'(e.tipo));
    chk({tag, "_ilegal_a"}, 64'(ilegal_a), 64'(e.ilegal));
    chk({tag, "_imm_a"},    64'(immediate_a), e.imm);
  endtask

  task automatic check_b(input string tag, input exp_t e);
    chk({tag, "_opcode_b"}, 64'(opcode_b), 64'(e.opcode));
    chk({tag, "_rd_b"},     64'(rd_b),     64'(e.rd));
    chk({tag, "_rs1_b"},    64'(rs1_b),    64'(e.rs1));
    chk({tag, "_rs2_b"},    64'(rs2_b),    64'(e.rs2));
    chk({tag, "_funct3_b"}, 64'(funct3_b), 64'(e.funct3));
    chk({tag, "_funct7_b"}, 64'(funct7_b), 64'(e.funct7));
    chk({tag, "_tipo_b"},   64'(tipo_b),   64'(e.tipo));
    chk({tag, "_ilegal_b"}, 64'(ilegal_b), 64'(e.ilegal));
    chk({tag, "_imm_b"},    immediate_b,   e.imm);
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z = '{default: '0};
    chk({tag, "_out_valid_a"}, 64'(out_valid_a), 64'd0);
    chk({tag, "_out_valid_b"}, 64'(out_valid_b), 64'd0);
    chk({tag, "_contador_a"},  64'(contador_a),  64'd0);
    chk({tag, "_contador_b"},  64'(contador_b),  64'd0);
    check_a(tag, z);
    check_b(tag, z);
  endtask

  // One clock: drive inputs, check registered state mid-cycle, advance model.
  task automatic cycle(input bit iv, input logic [31:0] inst, input bit ordy, input bit fl);
    bit cap;
    in_valid  = iv;
    instrucao = inst;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    chk("out_valid_a", 64'(out_valid_a), 64'(m_valid));
    chk("out_valid_b", 64'(out_valid_b), 64'(m_valid));
    chk("in_ready_a",  64'(in_ready_a),  64'(!m_valid || ordy));
    chk("in_ready_b",  64'(in_ready_b),  64'(!m_valid || ordy));
    chk("contador_a",  64'(contador_a),  64'(m_cnt_a));
    chk("contador_b",  64'(contador_b),  64'(m_cnt_b));
    if (m_valid) begin
      check_a("campos", m_a);
      check_b("campos", m_b);
    end
    cap = iv && (!m_valid || ordy) && !fl;
    if (m_valid && ordy) begin
      $display("saida opcode=%h tipo=%0d ilegal_a=%0d imm_b=%h flush=%0d",
               m_a.opcode, m_a.tipo, m_a.ilegal, m_b.imm, fl);
      if (!fl && !m_a.ilegal) m_cnt_a++;
      if (!fl && !m_b.ilegal) m_cnt_b++;
    end
    if (cap) begin
      m_valid = 1'b1;
      m_a = ref_decode(inst, 32, 1'b0);
      m_b = ref_decode(inst, 64, 1'b1);
    end else if (fl || ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  opcs [10];
    logic [6:0]  f7s [4];
    opcs = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h33, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    f7s  = '{7'h00, 7'h20, 7'h01, 7'h55};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 9)];
    if (r[6:0] == 7'h33) r[31:25] = f7s[$urandom_range(0, 3)];
    return r;
  endfunction

  vec_t vecs [12];

  initial begin
    logic [15:0] base;
    exp_t ea;
    vecs[0]  = '{"addi",  32'hFFF10093, 3'd0, 5'd1,  5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{"sw",    32'h00512423, 3'd2, 5'd0,  5'd2, 5'd5, 3'd2, 7'h00, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
    vecs[2]  = '{"beq",   32'hFE208EE3, 3'd6, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{"lui",   32'h123452B7, 3'd1, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{"zero",  32'h00000000, 3'd4, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
    vecs[5]  = '{"mul",   32'h02208033, 3'd3, 5'd0,  5'd1, 5'd2, 3'd0, 7'h01, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b0};
    vecs[6]  = '{"add",   32'h002081B3, 3'd3, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0};
    vecs[7]  = '{"sub",   32'h402081B3, 3'd3, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0};
    vecs[8]  = '{"jal",   32'hFFDFF06F, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[9]  = '{"auipc", 32'h00001517, 3'd1, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 1'b0, 64'h0000000000001000, 1'b0};
    vecs[10] = '{"jalr",  32'h00008067, 3'd0, 5'd0,  5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0};
    vecs[11] = '{"ones",  32'hFFFFFFFF, 3'd4, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; instrucao = 32'h0; flush = 1'b0; out_ready = 1'b0;
    m_valid = 1'b0; m_cnt_a = '0; m_cnt_b = '0;
    m_a = '{default: '0}; m_b = '{default: '0};
    #12;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: each vector goes in with out_ready high and is read one edge later.
    foreach (vecs[k]) begin
      cycle(1'b1, vecs[k].inst, 1'b1, 1'b0);
      chk({vecs[k].nome, "_valid"},  64'(out_valid_a), 64'd1);
      chk({vecs[k].nome, "_tipo"},   64'(tipo_a),      64'(vecs[k].tipo));
      chk({vecs[k].nome, "_rd"},     64'(rd_a),        64'(vecs[k].rd));
      chk({vecs[k].nome, "_rs1"},    64'(rs1_a),       64'(vecs[k].rs1));
      chk({vecs[k].nome, "_rs2"},    64'(rs2_a),       64'(vecs[k].rs2));
      chk({vecs[k].nome, "_funct3"}, 64'(funct3_a),    64'(vecs[k].funct3));
      chk({vecs[k].nome, "_funct7"}, 64'(funct7_a),    64'(vecs[k].funct7));
      chk({vecs[k].nome, "_imm32"},  64'(immediate_a), 64'(vecs[k].imm32));
      chk({vecs[k].nome, "_ilegal"}, 64'(ilegal_a),    64'(vecs[k].ilegal));
      chk({vecs[k].nome, "_imm64"},  immediate_b,      vecs[k].imm64);
      chk({vecs[k].nome, "_ilegal_m"}, 64'(ilegal_b),  64'(vecs[k].ilegal_m));
      $display("vetor %s inst=%h tipo=%0d imm=%h ilegal=%0d", vecs[k].nome,
               vecs[k].inst, tipo_a, immediate_a, ilegal_a);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: stall three cycles, then two legal instructions drain back to back.
    base = contador_a;
    cycle(1'b1, 32'hFFF10093, 1'b1, 1'b0);
    ea = ref_decode(32'hFFF10093, 32, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h002081B3, 1'b0, 1'b0);
      chk("bp_in_ready", 64'(in_ready_a), 64'd0);
      chk("bp_rd_stable", 64'(rd_a), 64'(ea.rd));
      chk("bp_imm_stable", 64'(immediate_a), ea.imm);
    end
    cycle(1'b1, 32'h002081B3, 1'b1, 1'b0);
    chk("bp_second_valid", 64'(out_valid_a), 64'd1);
    chk("bp_second_rd", 64'(rd_a), 64'd3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_contador_plus2", 64'(contador_a), 64'(base + 16'd2));
    $display("contrapressao contador=%0d", contador_a);

    // Flush while an entry is held and another is offered.
    cycle(1'b1, 32'h00512423, 1'b0, 1'b0);
    base = contador_a;
    cycle(1'b1, 32'h123452B7, 1'b1, 1'b1);
    chk("flush_out_valid", 64'(out_valid_a), 64'd0);
    chk("flush_contador", 64'(contador_a), 64'(base));
    $display("flush out_valid=%0d contador=%0d", out_valid_a, contador_a);

    // Asynchronous reset mid-stream, with an instruction waiting at release.
    cycle(1'b1, 32'hFE208EE3, 1'b1, 1'b0);
    in_valid = 1'b1; instrucao = 32'h00001517; out_ready = 1'b1; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    m_valid = 1'b0; m_cnt_a = '0; m_cnt_b = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b1;
    m_a = ref_decode(32'h00001517, 32, 1'b0);
    m_b = ref_decode(32'h00001517, 64, 1'b1);
    chk("rst_first_capture", 64'(out_valid_a), 64'd1);
    chk("rst_first_rd", 64'(rd_a), 64'd10);
    $display("reset assincrono liberado out_valid=%0d", out_valid_a);

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
